clb_serial_subtractor: RTL



---
 rtl/clb_serial_subtractor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/clb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// clb_serial_subtractor
//
// Bit-serial subtractor built from one full-adder cell. B is inverted and the
// registered carry starts at 1, so the cell computes A + ~B + 1 = A - B,
// LSB-first, one bit per clock.
//
// Parameters:
//   WIDTH  operand/result width (2..64)
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (in_a = minuend, in_b = subtrahend)
//   out_valid/out_ready result handshake
//   out_diff           A - B modulo 2^WIDTH
//   out_borrow         1 when A < B (unsigned)
//   out_eq             1 when out_diff == 0
//   busy               1 whenever the block is not idle
//   out_ovf            signed overflow of A - B (only with the macro below)
//
// Build option:
//   CLB_SERIAL_SUB_SIGNED_OVF_EN  adds out_ovf and its register.
// ----------------------------------------------------------------------------
module clb_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_eq,
`ifdef CLB_SERIAL_SUB_SIGNED_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             eq_r;
`ifdef CLB_SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf_r;
`endif

    logic             b_inv;
    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last_bit;

    always_comb begin
        b_inv     = ~b_sr[0];
        sum_bit   = a_sr[0] ^ b_inv ^ carry;
        carry_nxt = (a_sr[0] & b_inv) | (a_sr[0] & carry) | (b_inv & carry);
        res_nxt   = {sum_bit, res_sr[WIDTH-1:1]};
        last_bit  = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            eq_r     <= 1'b0;
`ifdef CLB_SERIAL_SUB_SIGNED_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= in_a;
                        b_sr  <= in_b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry  <= carry_nxt;
                    res_sr <= res_nxt;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // Result registers are loaded from the next-state
                        // values so they hold steady outside DONE.
                        state    <= DONE;
                        diff_r   <= res_nxt;
                        borrow_r <= ~carry_nxt;
                        eq_r     <= (res_nxt == '0);
`ifdef CLB_SERIAL_SUB_SIGNED_OVF_EN
                        // carry here is the carry into the MSB cell.
                        ovf_r    <= carry ^ carry_nxt;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign out_valid  = (state == DONE);
    assign out_diff   = diff_r;
    assign out_borrow = borrow_r;
    assign out_eq     = eq_r;
`ifdef CLB_SERIAL_SUB_SIGNED_OVF_EN
    assign out_ovf    = ovf_r;
`endif

endmodule
